// File: rtl/uart_tx_arb.sv
// Arbitrates the UART Tx FIFO write port between two byte-stream requesters.
// Packet-locked round-robin grants with a stall watchdog that revokes idle owners.
module uart_tx_arb #(
    parameter int TIMEOUT = 1023,
    parameter int TW      = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0_VALID,
    input  logic [7:0] REQ0_DATA,
    input  logic       REQ0_LAST,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic [7:0] REQ1_DATA,
    input  logic       REQ1_LAST,
    output logic       REQ1_READY,
    output logic       FIFO_WRITE,
    output logic [7:0] FIFO_WDATA,
    input  logic       FIFO_FULL,
    input  logic       FIFO_AFULL,
    output logic [1:0] GRANT,
    output logic       TIMEOUT_ERR
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [TW-1:0] wd_q, wd_d;
    logic          wr_q, wr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          err_q, err_d;

    logic          own0, own1, stall, xfer, expire;
    logic          cur_valid, cur_last;
    logic [7:0]    cur_data;

    // AFULL gating leaves room for the one registered write still in flight.
    assign stall      = FIFO_AFULL | FIFO_FULL;
    assign own0       = (state_q == OWN0);
    assign own1       = (state_q == OWN1);
    assign REQ0_READY = own0 & ~stall;
    assign REQ1_READY = own1 & ~stall;

    assign cur_valid = own1 ? REQ1_VALID : REQ0_VALID;
    assign cur_last  = own1 ? REQ1_LAST  : REQ0_LAST;
    assign cur_data  = own1 ? REQ1_DATA  : REQ0_DATA;

    assign xfer   = (REQ0_VALID & REQ0_READY) | (REQ1_VALID & REQ1_READY);
    // A transfer in the expiry cycle takes precedence over the revoke.
    assign expire = (own0 | own1) & ~xfer & ~stall & (wd_q == WD_LIMIT);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        wr_d    = xfer;
        wdata_d = xfer ? cur_data : wdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (REQ0_VALID & REQ1_VALID) begin
                    state_d = ptr_q ? OWN1 : OWN0;
                end else if (REQ0_VALID) begin
                    state_d = OWN0;
                end else if (REQ1_VALID) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (xfer) begin
                    wd_d = '0;
                    if (cur_last) begin
                        state_d = IDLE;
                        ptr_d   = own0;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    ptr_d   = own0;
                    wd_d    = '0;
                    err_d   = 1'b1;
                end else if (!stall && !cur_valid) begin
                    wd_d = wd_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            wd_q    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign GRANT       = {own1, own0};
    assign FIFO_WRITE  = wr_q;
    assign FIFO_WDATA  = wdata_q;
    assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus a randomized
// run scored against a per-requester packet model.
module tb_uart_tx_arb;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       REQ0_VALID, REQ0_LAST, REQ1_VALID, REQ1_LAST;
    logic [7:0] REQ0_DATA, REQ1_DATA;
    logic       REQ0_READY, REQ1_READY;
    logic       FIFO_WRITE;
    logic [7:0] FIFO_WDATA;
    logic       FIFO_FULL, FIFO_AFULL;
    logic [1:0] GRANT;
    logic       TIMEOUT_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    // requester byte queues and run logs
    logic [7:0] q0[$], q1[$];
    bit         l0[$], l1[$];
    logic [7:0] acc_d[$], wr_d[$];
    int         acc_t[$], wr_t[$];
    int         err_pulses, both_ready, ready_viol;

    uart_tx_arb #(.TIMEOUT(8), .TW(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_LAST(REQ0_LAST), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_LAST(REQ1_LAST), .REQ1_READY(REQ1_READY),
        .FIFO_WRITE(FIFO_WRITE), .FIFO_WDATA(FIFO_WDATA), .FIFO_FULL(FIFO_FULL), .FIFO_AFULL(FIFO_AFULL),
        .GRANT(GRANT), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        REQ0_VALID = 0; REQ0_DATA = 0; REQ0_LAST = 0;
        REQ1_VALID = 0; REQ1_DATA = 0; REQ1_LAST = 0;
        FIFO_AFULL = 0; FIFO_FULL = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge CLK); RST_N = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1;
    endtask

    // Drives both requesters from q0/q1, logs accepts and FIFO writes per cycle.
    task automatic run_reqs(input int max_cyc, input int stall_from, input int stall_len,
                            input bit drop_in_stall, input bit rand_mode);
        int cyc, tail;
        bit keep0, keep1, a0, a1, stall;
        cyc = 0; tail = 0; keep0 = 0; keep1 = 0;
        acc_d.delete(); acc_t.delete(); wr_d.delete(); wr_t.delete();
        err_pulses = 0; both_ready = 0; ready_viol = 0;
        while (cyc < max_cyc && tail < 3) begin
            @(negedge CLK);
            cyc++;
            if (FIFO_WRITE) begin wr_d.push_back(FIFO_WDATA); wr_t.push_back(cyc); end
            if (TIMEOUT_ERR) err_pulses++;
            stall = (cyc >= stall_from) && (cyc < stall_from + stall_len);
            FIFO_AFULL = stall || (rand_mode && ($urandom_range(0, 5) == 0));
            FIFO_FULL  = rand_mode && ($urandom_range(0, 11) == 0);
            REQ0_VALID = (q0.size() > 0) && (keep0 || !rand_mode || ($urandom_range(0, 2) == 0))
                         && !(stall && drop_in_stall);
            REQ1_VALID = (q1.size() > 0) && (keep1 || !rand_mode || ($urandom_range(0, 2) == 0))
                         && !(stall && drop_in_stall);
            REQ0_DATA = (q0.size() > 0) ? q0[0] : 8'h00;
            REQ0_LAST = (l0.size() > 0) ? l0[0] : 1'b0;
            REQ1_DATA = (q1.size() > 0) ? q1[0] : 8'h00;
            REQ1_LAST = (l1.size() > 0) ? l1[0] : 1'b0;
            #1;
            if (REQ0_READY && REQ1_READY) both_ready++;
            if ((REQ0_READY || REQ1_READY) && (FIFO_AFULL || FIFO_FULL)) ready_viol++;
            a0 = REQ0_VALID && REQ0_READY;
            a1 = REQ1_VALID && REQ1_READY;
            if (a0) begin
                acc_d.push_back(REQ0_DATA); acc_t.push_back(cyc);
                void'(q0.pop_front()); void'(l0.pop_front());
            end
            if (a1) begin
                acc_d.push_back(REQ1_DATA); acc_t.push_back(cyc);
                void'(q1.pop_front()); void'(l1.pop_front());
            end
            keep0 = REQ0_VALID && !(a0 && REQ0_LAST);
            keep1 = REQ1_VALID && !(a1 && REQ1_LAST);
            if (q0.size() == 0 && q1.size() == 0) tail++;
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        RST_N = 0;
        REQ0_VALID = 1; REQ1_VALID = 1; REQ0_DATA = 8'hFF; REQ0_LAST = 1;
        repeat (3) @(negedge CLK);
        #1;
        n_cmp++; if (GRANT !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b expected 00", GRANT); end
        n_cmp++; if ({REQ0_READY, REQ1_READY} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b expected 00", {REQ0_READY, REQ1_READY}); end
        n_cmp++; if (FIFO_WRITE !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b expected 0", FIFO_WRITE); end
        n_cmp++; if (FIFO_WDATA !== 8'h00) begin n_bad++; $display("FAIL reset_wdata: got %h expected 00", FIFO_WDATA); end
        n_cmp++; if (TIMEOUT_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", TIMEOUT_ERR); end
        clear_inputs();
        @(negedge CLK); RST_N = 1;
        @(negedge CLK);
        n_cmp++; if (GRANT !== 2'b00) begin n_bad++; $display("FAIL reset_idle_grant: got %b expected 00", GRANT); end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            case (c)
                0: begin
                    n_cmp++; if (GRANT !== 2'b00) begin n_bad++; $display("FAIL single_idle: got %b expected 00", GRANT); end
                    REQ0_VALID = 1; REQ0_DATA = 8'h41; REQ0_LAST = 0;
                    #1;
                    n_cmp++; if (REQ0_READY !== 1'b0) begin n_bad++; $display("FAIL single_idle_ready: got %b expected 0", REQ0_READY); end
                end
                1: begin
                    n_cmp++; if (GRANT !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b expected 01", GRANT); end
                    n_cmp++; if (REQ0_READY !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b expected 1", REQ0_READY); end
                end
                2: begin
                    n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b1, 8'h41}) begin n_bad++; $display("FAIL single_b0: got %b/%h expected 1/41", FIFO_WRITE, FIFO_WDATA); end
                    REQ0_DATA = 8'h42;
                end
                3: begin
                    n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b1, 8'h42}) begin n_bad++; $display("FAIL single_b1: got %b/%h expected 1/42", FIFO_WRITE, FIFO_WDATA); end
                    REQ0_DATA = 8'h43; REQ0_LAST = 1;
                end
                4: begin
                    n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b1, 8'h43}) begin n_bad++; $display("FAIL single_b2: got %b/%h expected 1/43", FIFO_WRITE, FIFO_WDATA); end
                    n_cmp++; if (GRANT !== 2'b00) begin n_bad++; $display("FAIL single_release: got %b expected 00", GRANT); end
                    REQ0_VALID = 0; REQ0_LAST = 0;
                end
                default: begin
                    n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b0, 8'h43}) begin n_bad++; $display("FAIL single_hold: got %b/%h expected 0/43", FIFO_WRITE, FIFO_WDATA); end
                end
            endcase
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp [0:7];
        exp = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h10, 8'h11, 8'h20, 8'h21};
        do_reset();
        q0 = '{8'h10, 8'h11, 8'h10, 8'h11}; l0 = '{0, 1, 0, 1};
        q1 = '{8'h20, 8'h21, 8'h20, 8'h21}; l1 = '{0, 1, 0, 1};
        run_reqs(60, 1000, 0, 0, 0);
        n_cmp++; if (wr_d.size() !== 8) begin n_bad++; $display("FAIL contention_count: got %0d expected 8", wr_d.size()); end
        for (int i = 0; i < 8 && i < wr_d.size(); i++) begin
            n_cmp++; if (wr_d[i] !== exp[i]) begin n_bad++; $display("FAIL contention_byte%0d: got %h expected %h", i, wr_d[i], exp[i]); end
        end
        n_cmp++; if (both_ready !== 0) begin n_bad++; $display("FAIL contention_both_ready: got %0d expected 0", both_ready); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [0:5];
        int stalled_writes;
        exp = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        do_reset();
        q0 = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5}; l0 = '{0, 0, 0, 0, 0, 1};
        q1.delete(); l1.delete();
        run_reqs(200, 4, 50, 1, 0);
        stalled_writes = 0;
        foreach (wr_t[i]) if (wr_t[i] >= 5 && wr_t[i] <= 54) stalled_writes++;
        n_cmp++; if (stalled_writes !== 0) begin n_bad++; $display("FAIL bp_write_in_stall: got %0d expected 0", stalled_writes); end
        n_cmp++; if (ready_viol !== 0) begin n_bad++; $display("FAIL bp_ready_in_stall: got %0d expected 0", ready_viol); end
        n_cmp++; if (err_pulses !== 0) begin n_bad++; $display("FAIL bp_timeout: got %0d expected 0", err_pulses); end
        n_cmp++; if (wr_d.size() !== 6) begin n_bad++; $display("FAIL bp_count: got %0d expected 6", wr_d.size()); end
        for (int i = 0; i < 6 && i < wr_d.size(); i++) begin
            n_cmp++; if (wr_d[i] !== exp[i]) begin n_bad++; $display("FAIL bp_byte%0d: got %h expected %h", i, wr_d[i], exp[i]); end
        end
    endtask

    task automatic test_watchdog();
        int errs, err_at;
        errs = 0; err_at = -1;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            if (TIMEOUT_ERR) begin errs++; if (err_at < 0) err_at = c; end
            case (c)
                1: begin n_cmp++; if (GRANT !== 2'b01) begin n_bad++; $display("FAIL wd_grant0: got %b expected 01", GRANT); end end
                2: begin n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b1, 8'h55}) begin n_bad++; $display("FAIL wd_byte: got %b/%h expected 1/55", FIFO_WRITE, FIFO_WDATA); end end
                10: begin n_cmp++; if (GRANT !== 2'b01) begin n_bad++; $display("FAIL wd_early_revoke: got %b expected 01", GRANT); end end
                11: begin n_cmp++; if (GRANT !== 2'b00) begin n_bad++; $display("FAIL wd_revoke: got %b expected 00", GRANT); end end
                12: begin
                    n_cmp++; if (GRANT !== 2'b10) begin n_bad++; $display("FAIL wd_grant1: got %b expected 10", GRANT); end
                    n_cmp++; if (REQ0_READY !== 1'b0) begin n_bad++; $display("FAIL wd_r0_ready: got %b expected 0", REQ0_READY); end
                end
                13: begin
                    n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b1, 8'h66}) begin n_bad++; $display("FAIL wd_r1_byte: got %b/%h expected 1/66", FIFO_WRITE, FIFO_WDATA); end
                end
                14: begin n_cmp++; if (GRANT !== 2'b01) begin n_bad++; $display("FAIL wd_regrant0: got %b expected 01", GRANT); end end
                15: begin n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b1, 8'h77}) begin n_bad++; $display("FAIL wd_r0_byte: got %b/%h expected 1/77", FIFO_WRITE, FIFO_WDATA); end end
                default: ;
            endcase
            case (c)
                0: begin REQ0_VALID = 1; REQ0_DATA = 8'h55; REQ0_LAST = 0; end
                2: begin REQ0_VALID = 0; REQ1_VALID = 1; REQ1_DATA = 8'h66; REQ1_LAST = 1; end
                11: begin REQ0_VALID = 1; REQ0_DATA = 8'h77; REQ0_LAST = 1; end
                13: REQ1_VALID = 0;
                15: REQ0_VALID = 0;
                default: ;
            endcase
        end
        n_cmp++; if (errs !== 1) begin n_bad++; $display("FAIL wd_pulse_count: got %0d expected 1", errs); end
        n_cmp++; if (err_at !== 11) begin n_bad++; $display("FAIL wd_pulse_cycle: got %0d expected 11", err_at); end
        clear_inputs();
    endtask

    task automatic test_expiry_vs_last();
        int errs;
        errs = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK);
            if (TIMEOUT_ERR) errs++;
            case (c)
                2: begin n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b1, 8'h31}) begin n_bad++; $display("FAIL exp_first: got %b/%h expected 1/31", FIFO_WRITE, FIFO_WDATA); end end
                10: begin n_cmp++; if (GRANT !== 2'b01) begin n_bad++; $display("FAIL exp_grant: got %b expected 01", GRANT); end end
                11: begin
                    n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b1, 8'h32}) begin n_bad++; $display("FAIL exp_last_byte: got %b/%h expected 1/32", FIFO_WRITE, FIFO_WDATA); end
                    n_cmp++; if (GRANT !== 2'b00) begin n_bad++; $display("FAIL exp_release: got %b expected 00", GRANT); end
                end
                default: ;
            endcase
            case (c)
                0: begin REQ0_VALID = 1; REQ0_DATA = 8'h31; REQ0_LAST = 0; end
                2: REQ0_VALID = 0;
                10: begin REQ0_VALID = 1; REQ0_DATA = 8'h32; REQ0_LAST = 1; end
                11: REQ0_VALID = 0;
                default: ;
            endcase
        end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL exp_timeout_err: got %0d expected 0", errs); end
        clear_inputs();
    endtask

    task automatic test_reset_midpacket();
        do_reset();
        @(negedge CLK); REQ1_VALID = 1; REQ1_DATA = 8'hA1; REQ1_LAST = 0;
        @(negedge CLK);
        n_cmp++; if (GRANT !== 2'b10) begin n_bad++; $display("FAIL rst_grant1: got %b expected 10", GRANT); end
        @(negedge CLK);
        n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b1, 8'hA1}) begin n_bad++; $display("FAIL rst_first: got %b/%h expected 1/A1", FIFO_WRITE, FIFO_WDATA); end
        REQ1_DATA = 8'hA2;
        #2 RST_N = 0;
        #1;
        n_cmp++; if (GRANT !== 2'b00) begin n_bad++; $display("FAIL rst_mid_grant: got %b expected 00", GRANT); end
        n_cmp++; if (REQ1_READY !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready: got %b expected 0", REQ1_READY); end
        n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== 9'h000) begin n_bad++; $display("FAIL rst_mid_write: got %b/%h expected 0/00", FIFO_WRITE, FIFO_WDATA); end
        n_cmp++; if (TIMEOUT_ERR !== 1'b0) begin n_bad++; $display("FAIL rst_mid_err: got %b expected 0", TIMEOUT_ERR); end
        REQ1_VALID = 0;
        @(negedge CLK); @(negedge CLK); RST_N = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            n_cmp++; if ({GRANT, FIFO_WRITE} !== 3'b000) begin n_bad++; $display("FAIL rst_after_c%0d: got %b/%b expected 00/0", c, GRANT, FIFO_WRITE); end
        end
        REQ1_VALID = 1; REQ1_DATA = 8'hB5; REQ1_LAST = 1;
        @(negedge CLK);
        n_cmp++; if (GRANT !== 2'b10) begin n_bad++; $display("FAIL rst_regrant: got %b expected 10", GRANT); end
        @(negedge CLK);
        REQ1_VALID = 0;
        n_cmp++; if ({FIFO_WRITE, FIFO_WDATA} !== {1'b1, 8'hB5}) begin n_bad++; $display("FAIL rst_new_byte: got %b/%h expected 1/B5", FIFO_WRITE, FIFO_WDATA); end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [7:0] e0[$], e1[$], b;
        bit         el0[$], el1[$], lst;
        int         total, open, own, len;
        total = 0;
        do_reset();
        q0.delete(); l0.delete(); q1.delete(); l1.delete();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 6; p++) begin
                len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) begin
                    b = {k[0], 7'($urandom_range(0, 127))};
                    lst = (i == len - 1);
                    if (k == 0) begin q0.push_back(b); l0.push_back(lst); e0.push_back(b); el0.push_back(lst); end
                    else        begin q1.push_back(b); l1.push_back(lst); e1.push_back(b); el1.push_back(lst); end
                    total++;
                end
            end
        end
        run_reqs(3000, 100000, 0, 0, 1);
        n_cmp++; if (wr_d.size() !== total) begin n_bad++; $display("FAIL rnd_count: got %0d expected %0d", wr_d.size(), total); end
        n_cmp++; if (ready_viol !== 0) begin n_bad++; $display("FAIL rnd_ready_when_full: got %0d expected 0", ready_viol); end
        n_cmp++; if (both_ready !== 0) begin n_bad++; $display("FAIL rnd_both_ready: got %0d expected 0", both_ready); end
        n_cmp++; if (err_pulses !== 0) begin n_bad++; $display("FAIL rnd_timeout: got %0d expected 0", err_pulses); end
        open = -1;
        foreach (wr_d[i]) begin
            own = int'(wr_d[i][7]);
            if (open >= 0) begin
                n_cmp++; if (own !== open) begin n_bad++; $display("FAIL rnd_interleave%0d: got owner %0d expected %0d", i, own, open); end
            end
            if (own == 0 && e0.size() > 0) begin b = e0.pop_front(); lst = el0.pop_front(); end
            else if (own == 1 && e1.size() > 0) begin b = e1.pop_front(); lst = el1.pop_front(); end
            else begin b = 8'hxx; lst = 1'b1; end
            n_cmp++; if (wr_d[i] !== b) begin n_bad++; $display("FAIL rnd_byte%0d: got %h expected %h", i, wr_d[i], b); end
            open = lst ? -1 : own;
            if (i < acc_t.size()) begin
                n_cmp++; if (wr_t[i] !== acc_t[i] + 1) begin n_bad++; $display("FAIL rnd_latency%0d: got cycle %0d expected %0d", i, wr_t[i], acc_t[i] + 1); end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_watchdog();
        test_expiry_vs_last();
        test_reset_midpacket();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
